// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit splitting misaligned accesses into two aligned bus beats
module lsu_unit #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_zero_extend,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);
  localparam int W = XLEN / 8;
  localparam int OW = $clog2(W);
  typedef enum logic [2:0] {IDLE, ISSUE0, RD0, ISSUE1, RD1, RESP} state_t;
  state_t state, state_nx;
  logic              write_r, zext_r, fault_r, two_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r, base;
  logic [XLEN-1:0]   wdata_r, b0, b1, dmask, lsh, ext;
  logic [OW-1:0]     off, req_off;
  logic [3:0]        req_nb;
  logic              req_two, req_fault, sign;
  logic [W-1:0]      m_w;
  logic [2*W-1:0]    strb_full;
  logic [2*XLEN-1:0] data_full;
  assign req_off   = req_addr[OW-1:0];
  assign req_nb    = req_size == 2'b00 ? 4'd1 : req_size == 2'b01 ? 4'd2 : req_size == 2'b11 ? 4'd4 : 4'd8;
  assign req_two   = (5'(req_off) + 5'(req_nb)) > 5'(W);
  assign req_fault = (XLEN == 32 && req_size == 2'b10) || (!ALLOW_MISALIGNED && req_two);
  assign off       = addr_r[OW-1:0];
  assign base      = {addr_r[ADDR_W-1:OW], {OW{1'b0}}};
  assign m_w       = W'(size_r == 2'b00 ? 8'h01 : size_r == 2'b01 ? 8'h03 : size_r == 2'b11 ? 8'h0F : 8'hFF);
  for (genvar g = 0; g < W; g++) begin : g_mask
    assign dmask[8*g +: 8] = {8{m_w[g]}};
  end
  assign strb_full = {{W{1'b0}}, m_w} << off;
  assign data_full = {{XLEN{1'b0}}, wdata_r & dmask} << {off, 3'b000};
  assign lsh       = XLEN'({b1, b0} >> {off, 3'b000}) & dmask;
  assign sign      = |(lsh & dmask & ~(dmask >> 1));
  assign ext       = (zext_r || !sign) ? lsh : lsh | ~dmask;
  assign req_ready = state == IDLE;
  assign bus_valid = state == ISSUE0 || state == ISSUE1;
  assign bus_write = bus_valid && write_r;
  assign bus_addr  = state == ISSUE0 ? base : state == ISSUE1 ? base + ADDR_W'(W) : '0;
  assign bus_wstrb = state == ISSUE0 ? strb_full[W-1:0] : state == ISSUE1 ? strb_full[2*W-1:W] : '0;
  assign bus_wdata = state == ISSUE0 ? data_full[XLEN-1:0] : state == ISSUE1 ? data_full[2*XLEN-1:XLEN] : '0;
  assign rsp_valid = state == RESP;
  assign rsp_fault = rsp_valid && fault_r;
  assign rsp_rdata = (rsp_valid && !write_r && !fault_r) ? ext : '0;
  // next-state selection for the request/beat sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = req_fault ? RESP : ISSUE0;
      ISSUE0:  if (bus_ready) state_nx = !write_r ? RD0 : two_r ? ISSUE1 : RESP;
      RD0:     if (bus_rvalid) state_nx = two_r ? ISSUE1 : RESP;
      ISSUE1:  if (bus_ready) state_nx = write_r ? RESP : RD1;
      RD1:     if (bus_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // request capture on acceptance and read beat capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r <= 1'b0;
      zext_r  <= 1'b0;
      fault_r <= 1'b0;
      two_r   <= 1'b0;
      size_r  <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      b0      <= '0;
      b1      <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        write_r <= req_write;
        zext_r  <= req_zero_extend;
        fault_r <= req_fault;
        two_r   <= req_two;
        size_r  <= req_size;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (state == RD0 && bus_rvalid) b0 <= bus_rdata;
      if (state == RD1 && bus_rvalid) b1 <= bus_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed checks of lsu_unit (XLEN=32) with and without misaligned support
module tb_lsu_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, n_req_valid = 1'b0, req_write = 1'b0, req_zero_extend = 1'b0;
  logic bus_ready = 1'b1, bus_rvalid = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, bus_rdata = '0;
  logic req_ready, rsp_valid, rsp_fault, bus_valid, bus_write;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic [3:0] bus_wstrb;
  logic n_req_ready, n_rsp_valid, n_rsp_fault, n_bus_valid, n_bus_write;
  logic [31:0] n_rsp_rdata, n_bus_addr, n_bus_wdata;
  logic [3:0] n_bus_wstrb;
  int checks = 0, failures = 0;
  lsu_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_zero_extend(req_zero_extend),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );
  lsu_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_write(req_write), .req_size(req_size), .req_zero_extend(req_zero_extend),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(n_rsp_valid),
    .rsp_rdata(n_rsp_rdata), .rsp_fault(n_rsp_fault), .bus_valid(n_bus_valid),
    .bus_ready(bus_ready), .bus_write(n_bus_write), .bus_addr(n_bus_addr),
    .bus_wdata(n_bus_wdata), .bus_wstrb(n_bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic w, input logic [1:0] sz, input logic zx, input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_size = sz; req_zero_extend = zx; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // LW 0x100, aligned single beat
    send(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    chk("lw_bus_valid", bus_valid, 1);
    chk("lw_bus_addr", bus_addr, 32'h100);
    chk("lw_wstrb", bus_wstrb, 4'b1111);
    chk("lw_bus_write", bus_write, 0);
    chk("lw_req_ready", req_ready, 0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    chk("lw_rsp_early", rsp_valid, 0);
    chk("lw_bus_valid_off", bus_valid, 0);
    tick();
    bus_rvalid = 1'b0;
    chk("lw_rsp_valid", rsp_valid, 1);
    chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("lw_fault", rsp_fault, 0);
    tick();
    chk("lw_rsp_pulse", rsp_valid, 0);
    chk("lw_ready_back", req_ready, 1);
    // LB 0x103 sign-extended
    send(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lb_bus_addr", bus_addr, 32'h100);
    chk("lb_wstrb", bus_wstrb, 4'b1000);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h80123456;
    tick();
    bus_rvalid = 1'b0;
    chk("lb_rsp_valid", rsp_valid, 1);
    chk("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    tick();
    // LBU 0x103 zero-extended
    send(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h80123456;
    tick();
    bus_rvalid = 1'b0;
    chk("lbu_rsp_valid", rsp_valid, 1);
    chk("lbu_rdata", rsp_rdata, 32'h00000080);
    tick();
    // SW 0x102, split into two beats
    send(1'b1, 2'b11, 1'b0, 32'h102, 32'h11223344);
    chk("sw_b0_valid", bus_valid, 1);
    chk("sw_b0_write", bus_write, 1);
    chk("sw_b0_addr", bus_addr, 32'h100);
    chk("sw_b0_wstrb", bus_wstrb, 4'b1100);
    chk("sw_b0_wdata", bus_wdata, 32'h33440000);
    tick();
    chk("sw_b1_valid", bus_valid, 1);
    chk("sw_b1_addr", bus_addr, 32'h104);
    chk("sw_b1_wstrb", bus_wstrb, 4'b0011);
    chk("sw_b1_wdata", bus_wdata, 32'h00001122);
    chk("sw_rsp_early", rsp_valid, 0);
    tick();
    chk("sw_rsp_valid", rsp_valid, 1);
    chk("sw_rdata", rsp_rdata, 0);
    chk("sw_bus_idle", bus_valid, 0);
    tick();
    chk("sw_rsp_pulse", rsp_valid, 0);
    // SB 0x101, upper store data bits must not leak into other lanes
    send(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFA5);
    chk("sb_wstrb", bus_wstrb, 4'b0010);
    chk("sb_wdata", bus_wdata, 32'h0000A500);
    tick();
    chk("sb_rsp_valid", rsp_valid, 1);
    tick();
    // LH 0xFFFFFFFF, wraps to address 0 for the second beat
    send(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    chk("lh_b0_addr", bus_addr, 32'hFFFFFFFC);
    chk("lh_b0_wstrb", bus_wstrb, 4'b1000);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hAB000000;
    tick();
    bus_rvalid = 1'b0;
    chk("lh_b1_valid", bus_valid, 1);
    chk("lh_b1_addr", bus_addr, 32'h00000000);
    chk("lh_b1_wstrb", bus_wstrb, 4'b0001);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h000000CD;
    chk("lh_rsp_early", rsp_valid, 0);
    tick();
    bus_rvalid = 1'b0;
    chk("lh_rsp_valid", rsp_valid, 1);
    chk("lh_rdata", rsp_rdata, 32'hFFFFCDAB);
    tick();
    // DOUBLE with XLEN=32 faults
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("dbl_bus_valid", bus_valid, 0);
    chk("dbl_rsp_valid", rsp_valid, 1);
    chk("dbl_fault", rsp_fault, 1);
    chk("dbl_rdata", rsp_rdata, 0);
    tick();
    chk("dbl_rsp_pulse", rsp_valid, 0);
    // misaligned LW faults when splitting is disabled
    req_write = 1'b0; req_size = 2'b11; req_zero_extend = 1'b0; req_addr = 32'h101;
    n_req_valid = 1'b1;
    tick();
    n_req_valid = 1'b0;
    chk("na_bus_valid", n_bus_valid, 0);
    chk("na_rsp_valid", n_rsp_valid, 1);
    chk("na_fault", n_rsp_fault, 1);
    chk("na_rdata", n_rsp_rdata, 0);
    tick();
    chk("na_rsp_pulse", n_rsp_valid, 0);
    // aligned LW still works when splitting is disabled
    req_addr = 32'h100;
    n_req_valid = 1'b1;
    tick();
    n_req_valid = 1'b0;
    chk("na_lw_bus_valid", n_bus_valid, 1);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
    tick();
    bus_rvalid = 1'b0;
    chk("na_lw_rsp_valid", n_rsp_valid, 1);
    chk("na_lw_fault", n_rsp_fault, 0);
    chk("na_lw_rdata", n_rsp_rdata, 32'h0BADF00D);
    tick();
    // bus stall, then reset mid-ISSUE0
    bus_ready = 1'b0;
    send(1'b0, 2'b11, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bus_valid", bus_valid, 1);
      chk("stall_bus_addr", bus_addr, 32'h200);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_valid", bus_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    #2 rst_n = 1'b1;
    bus_ready = 1'b1;
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_rvalid = 1'b0;
    chk("stray_rsp_valid0", rsp_valid, 0);
    tick();
    chk("stray_rsp_valid1", rsp_valid, 0);
    chk("stray_req_ready", req_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
